fp_mul_pipe_n: RTL and testbench

Parametrised successor to the single-precision pipelined multiplier used in the inverse-square-root datapath (y*(1.5-0.5*x*y*y) chain). It adds configurable exponent and mantissa widths, configurable pipeline depth and a selectable rounding mode. It also adds signed special-case handling, overflow/underflow flags and a sideband word that is carried in lockstep with each product. It sits between Newton-iteration stages and propagates error and backpressure upstream.

---
 rtl/fp_mul_pipe_n.sv | 150 +++++++++++++++
 tb/tb_fp_mul_pipe_n.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe_n.sv
// Parametrised pipelined floating-point multiplier with flush-to-zero, selectable rounding,
// overflow/underflow flags and a sideband word that travels in lockstep with each product.
module fp_mul_pipe_n #(
  parameter int STAGES   = 1,
  parameter int W_EXP    = 8,
  parameter int W_MAN    = 23,
  parameter int BIAS     = 127,
  parameter int SIDE_W   = 32,
  parameter int ROUND_NE = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   backprn,
  input  logic                   valid,
  input  logic [W_EXP+W_MAN:0]   float_in_1,
  input  logic [W_EXP+W_MAN:0]   float_in_2,
  input  logic [SIDE_W-1:0]      side_in,
  input  logic                   error_in,
  output logic                   in_ready,
  output logic                   ready,
  output logic [W_EXP+W_MAN:0]   float_out,
  output logic [SIDE_W-1:0]      side_out,
  output logic                   error_out,
  output logic                   ovf,
  output logic                   unf
);
  localparam int W  = 1 + W_EXP + W_MAN;
  localparam int MW = W_MAN + 1;
  localparam int EW = W_EXP + 2;

  logic              en;
  logic              s0_valid, s0_err;
  logic [W-1:0]      s0_a, s0_b;
  logic [SIDE_W-1:0] s0_side;

  logic              sign;
  logic [W_EXP-1:0]  exp_a, exp_b;
  logic [W_MAN-1:0]  man_a, man_b;
  logic [2*MW-1:0]   prod;
  logic [2*MW-2:0]   norm;
  logic [W_MAN-1:0]  man_t;
  logic              guard, sticky, round_up;
  logic [W_MAN:0]    man_r;
  logic [EW-1:0]     exp_r;
  logic              exp_ovf, exp_unf;

  logic [W-1:0]      res_f;
  logic              res_err, res_ovf, res_unf;

  logic [STAGES-1:0]             d_valid, d_err, d_ovf, d_unf;
  logic [STAGES-1:0][W-1:0]      d_f;
  logic [STAGES-1:0][SIDE_W-1:0] d_side;

  // A single global enable: the whole pipe freezes only when the output is held unread.
  assign en       = backprn | ~ready;
  assign in_ready = en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_valid <= 1'b0;
      s0_err   <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
      s0_side  <= '0;
    end else if (en) begin
      s0_valid <= valid;
      s0_err   <= error_in;
      s0_a     <= float_in_1;
      s0_b     <= float_in_2;
      s0_side  <= side_in;
    end
  end

  assign sign  = s0_a[W-1] ^ s0_b[W-1];
  assign exp_a = s0_a[W-2:W_MAN];
  assign exp_b = s0_b[W-2:W_MAN];
  assign man_a = s0_a[W_MAN-1:0];
  assign man_b = s0_b[W_MAN-1:0];

  assign prod     = {{MW{1'b0}}, 1'b1, man_a} * {{MW{1'b0}}, 1'b1, man_b};
  assign norm     = prod[2*MW-1] ? prod[2*MW-2:0] : {prod[2*MW-3:0], 1'b0};
  assign man_t    = norm[2*MW-2 -: W_MAN];
  assign guard    = norm[W_MAN];
  assign sticky   = |norm[W_MAN-1:0];
  assign round_up = (ROUND_NE != 0) && guard && (sticky || man_t[0]);
  assign man_r    = {1'b0, man_t} + {{W_MAN{1'b0}}, round_up};

  // Two extra exponent bits keep the sign and the overflow headroom of the biased sum.
  assign exp_r   = {2'b00, exp_a} + {2'b00, exp_b} - EW'(BIAS)
                 + {{(EW-1){1'b0}}, prod[2*MW-1]} + {{(EW-1){1'b0}}, man_r[W_MAN]};
  assign exp_ovf = !exp_r[EW-1] && (exp_r >= EW'((1 << W_EXP) - 1));
  assign exp_unf = exp_r[EW-1] || (exp_r == '0);

  always_comb begin
    res_f   = '0;
    res_err = s0_err;
    res_ovf = 1'b0;
    res_unf = 1'b0;
    if ((&exp_a) || (&exp_b)) begin
      res_f   = {sign, {W_EXP{1'b1}}, {W_MAN{1'b0}}};
      res_err = 1'b1;
    end else if ((~|exp_a) || (~|exp_b)) begin
      res_f   = {sign, {(W-1){1'b0}}};
      res_unf = ((~|exp_a) && (|man_a)) || ((~|exp_b) && (|man_b));
    end else if (exp_ovf) begin
      res_f   = {sign, {W_EXP{1'b1}}, {W_MAN{1'b0}}};
      res_ovf = 1'b1;
      res_err = 1'b1;
    end else if (exp_unf) begin
      res_f   = {sign, {(W-1){1'b0}}};
      res_unf = 1'b1;
    end else begin
      res_f   = {sign, exp_r[W_EXP-1:0], man_r[W_MAN-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_valid <= '0;
      d_err   <= '0;
      d_ovf   <= '0;
      d_unf   <= '0;
      d_f     <= '0;
      d_side  <= '0;
    end else if (en) begin
      d_valid[0] <= s0_valid;
      d_err[0]   <= res_err;
      d_ovf[0]   <= res_ovf;
      d_unf[0]   <= res_unf;
      d_f[0]     <= res_f;
      d_side[0]  <= s0_side;
      for (int i = 1; i < STAGES; i++) begin
        d_valid[i] <= d_valid[i-1];
        d_err[i]   <= d_err[i-1];
        d_ovf[i]   <= d_ovf[i-1];
        d_unf[i]   <= d_unf[i-1];
        d_f[i]     <= d_f[i-1];
        d_side[i]  <= d_side[i-1];
      end
    end
  end

  assign ready     = d_valid[STAGES-1];
  assign float_out = d_f[STAGES-1];
  assign side_out  = d_side[STAGES-1];
  assign error_out = d_err[STAGES-1];
  assign ovf       = d_ovf[STAGES-1];
  assign unf       = d_unf[STAGES-1];

endmodule

// File: tb/tb_fp_mul_pipe_n.sv
// Bench for fp_mul_pipe_n: a 4-stage round-to-nearest-even instance and a 1-stage truncating
// instance share one stimulus stream; each has its own scoreboard fed by a reference model.
module tb_fp_mul_pipe_n;
  typedef struct packed {
    logic [31:0] side;
    logic        err;
    logic        ovf;
    logic        unf;
    logic [31:0] f;
  } exp_t;

  localparam logic [31:0] TA [12] = '{32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h7F000000,
                                      32'h80000000, 32'h00800000, 32'h7FC00000, 32'h80400000,
                                      32'h3FFFFFFE, 32'h20000000, 32'h20000000, 32'h7F7FFFFE};
  localparam logic [31:0] TB [12] = '{32'h40400000, 32'h3FC00000, 32'h3FC00000, 32'h40000000,
                                      32'h40400000, 32'h00800000, 32'h3F800000, 32'h3F800000,
                                      32'h3F800001, 32'h1F800000, 32'h20000000, 32'h3F800001};
  localparam logic [31:0] TR [12] = '{32'h40C00000, 32'h40100000, 32'h3FC00002, 32'h7F800000,
                                      32'h80000000, 32'h00000000, 32'h7F800000, 32'h80000000,
                                      32'h40000000, 32'h00000000, 32'h00800000, 32'h7F800000};
  localparam logic [31:0] TT [12] = '{32'h40C00000, 32'h40100000, 32'h3FC00001, 32'h7F800000,
                                      32'h80000000, 32'h00000000, 32'h7F800000, 32'h80000000,
                                      32'h3FFFFFFF, 32'h00000000, 32'h00800000, 32'h7F7FFFFF};
  // Flag triples are {ovf, unf, error_out}.
  localparam logic [2:0] FR [12] = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b000, 3'b010,
                                     3'b001, 3'b010, 3'b000, 3'b010, 3'b000, 3'b101};
  localparam logic [2:0] FT [12] = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b000, 3'b010,
                                     3'b001, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000};

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        backprn = 1'b1;
  logic        valid = 1'b0;
  logic        error_in = 1'b0;
  logic [31:0] float_in_1 = '0;
  logic [31:0] float_in_2 = '0;
  logic [31:0] side_in = '0;

  logic        in_ready_4, ready_4, error_out_4, ovf_4, unf_4;
  logic [31:0] float_out_4, side_out_4;
  logic        in_ready_1, ready_1, error_out_1, ovf_1, unf_1;
  logic [31:0] float_out_1, side_out_1;

  int   checks = 0;
  int   errors = 0;
  exp_t q4[$];
  exp_t q1[$];

  fp_mul_pipe_n #(.STAGES(4), .ROUND_NE(1)) dut4 (
    .clk(clk), .rstn(rstn), .backprn(backprn), .valid(valid),
    .float_in_1(float_in_1), .float_in_2(float_in_2), .side_in(side_in), .error_in(error_in),
    .in_ready(in_ready_4), .ready(ready_4), .float_out(float_out_4), .side_out(side_out_4),
    .error_out(error_out_4), .ovf(ovf_4), .unf(unf_4)
  );

  fp_mul_pipe_n #(.STAGES(1), .ROUND_NE(0)) dut1 (
    .clk(clk), .rstn(rstn), .backprn(backprn), .valid(valid),
    .float_in_1(float_in_1), .float_in_2(float_in_2), .side_in(side_in), .error_in(error_in),
    .in_ready(in_ready_1), .ready(ready_1), .float_out(float_out_1), .side_out(side_out_1),
    .error_out(error_out_1), .ovf(ovf_1), .unf(unf_1)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product, then shift/remainder rounding against the half-ulp point.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] side, input logic err_in, input bit rne);
    exp_t r;
    int ea, eb, e, sh;
    longint unsigned ma, mb, p, q, rem, half;
    logic s;
    r.side = side; r.err = err_in; r.ovf = 1'b0; r.unf = 1'b0;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) begin
      r.f = {s, 8'hFF, 23'h0}; r.err = 1'b1;
      return r;
    end
    if (ea == 0 || eb == 0) begin
      r.f = {s, 31'h0};
      r.unf = (ea == 0 && a[22:0] != 0) || (eb == 0 && b[22:0] != 0);
      return r;
    end
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    e  = ea + eb - 127 + ((sh == 24) ? 1 : 0);
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rne && (rem > half || (rem == half && q[0]))) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e = e + 1;
    end
    if (e >= 255) begin
      r.f = {s, 8'hFF, 23'h0}; r.ovf = 1'b1; r.err = 1'b1;
    end else if (e <= 0) begin
      r.f = {s, 31'h0}; r.unf = 1'b1;
    end else begin
      r.f = {s, 8'(e), q[22:0]};
    end
    return r;
  endfunction

  // Scoreboard: enqueue on acceptance, dequeue and compare on every consumed output.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (ready_4 && backprn) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_s4_extra: got unexpected output f=%h side=%h, want none",
                   float_out_4, side_out_4);
        end else begin
          e = q4.pop_front();
          if ({side_out_4, error_out_4, ovf_4, unf_4, float_out_4} !== e) begin
            errors++;
            $display("[TB] FAIL sb_s4: got side=%h err=%b ovf=%b unf=%b f=%h, want side=%h err=%b ovf=%b unf=%b f=%h",
                     side_out_4, error_out_4, ovf_4, unf_4, float_out_4, e.side, e.err, e.ovf, e.unf, e.f);
          end
        end
      end
      if (ready_1 && backprn) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_s1_extra: got unexpected output f=%h side=%h, want none",
                   float_out_1, side_out_1);
        end else begin
          e = q1.pop_front();
          if ({side_out_1, error_out_1, ovf_1, unf_1, float_out_1} !== e) begin
            errors++;
            $display("[TB] FAIL sb_s1: got side=%h err=%b ovf=%b unf=%b f=%h, want side=%h err=%b ovf=%b unf=%b f=%h",
                     side_out_1, error_out_1, ovf_1, unf_1, float_out_1, e.side, e.err, e.ovf, e.unf, e.f);
          end
        end
      end
      if (valid && in_ready_4) q4.push_back(model(float_in_1, float_in_2, side_in, error_in, 1'b1));
      if (valid && in_ready_1) q1.push_back(model(float_in_1, float_in_2, side_in, error_in, 1'b0));
    end
  end

  task automatic drain();
    valid   = 1'b0;
    backprn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (q4.size() == 0 && q1.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (q4.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got pending s4=%0d s1=%0d, want 0 0", q4.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({ready_4, ready_1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b, want 00", {ready_4, ready_1});
    end
    checks++;
    if ({float_out_4, side_out_4, error_out_4, ovf_4, unf_4} !== 67'd0) begin
      errors++;
      $display("[TB] FAIL reset_out_s4: got f=%h side=%h flags=%b, want zeros",
               float_out_4, side_out_4, {error_out_4, ovf_4, unf_4});
    end
    checks++;
    if ({float_out_1, side_out_1, error_out_1, ovf_1, unf_1} !== 67'd0) begin
      errors++;
      $display("[TB] FAIL reset_out_s1: got f=%h side=%h flags=%b, want zeros",
               float_out_1, side_out_1, {error_out_1, ovf_1, unf_1});
    end
    valid = 1'b1; float_in_1 = TA[0]; float_in_2 = TB[0];
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready_4, ready_1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_hold: got ready %b, want 00", {ready_4, ready_1});
    end
    valid = 1'b0;
    rstn  = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 12; i++) begin
      valid = 1'b1; float_in_1 = TA[i]; float_in_2 = TB[i];
      side_in = 32'(100 + i); error_in = 1'b0;
      @(posedge clk); #1;
      valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({ready_1, ready_4} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL basic_lat1[%0d]: got ready_1,ready_4=%b, want 10", i, {ready_1, ready_4});
      end
      checks++;
      if (float_out_1 !== TT[i] || {ovf_1, unf_1, error_out_1} !== FT[i]) begin
        errors++;
        $display("[TB] FAIL basic_s1[%0d]: got f=%h flags=%b, want f=%h flags=%b",
                 i, float_out_1, {ovf_1, unf_1, error_out_1}, TT[i], FT[i]);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ready_4 !== 1'b1 || float_out_4 !== TR[i] || {ovf_4, unf_4, error_out_4} !== FR[i]) begin
        errors++;
        $display("[TB] FAIL basic_s4[%0d]: got ready=%b f=%h flags=%b, want ready=1 f=%h flags=%b",
                 i, ready_4, float_out_4, {ovf_4, unf_4, error_out_4}, TR[i], FR[i]);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [10];
    logic [31:0] vb [10];
    logic [66:0] held4, held1;
    int i = 0;
    int c = 0;
    for (int k = 0; k < 10; k++) begin
      va[k] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
      vb[k] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    end
    held4 = '0;
    held1 = '0;
    while (i < 10 && c < 40) begin
      backprn    = !(c >= 6 && c < 9);
      valid      = 1'b1;
      float_in_1 = va[i];
      float_in_2 = vb[i];
      side_in    = 32'(i);
      error_in   = (i == 3);
      if (c == 6) begin
        held4 = {float_out_4, side_out_4, error_out_4, ovf_4, unf_4};
        held1 = {float_out_1, side_out_1, error_out_1, ovf_1, unf_1};
      end
      @(negedge clk);
      if (!backprn) begin
        checks++;
        if ({ready_4, ready_1, in_ready_4, in_ready_1} !== 4'b1100) begin
          errors++;
          $display("[TB] FAIL stall_ready c=%0d: got ready/in_ready=%b, want 1100",
                   c, {ready_4, ready_1, in_ready_4, in_ready_1});
        end
        checks++;
        if ({float_out_4, side_out_4, error_out_4, ovf_4, unf_4} !== held4 ||
            {float_out_1, side_out_1, error_out_1, ovf_1, unf_1} !== held1) begin
          errors++;
          $display("[TB] FAIL stall_hold c=%0d: got f4=%h s4=%h f1=%h s1=%h, want f4=%h s4=%h f1=%h s1=%h",
                   c, float_out_4, side_out_4, float_out_1, side_out_1,
                   held4[66:35], held4[34:3], held1[66:35], held1[34:3]);
        end
      end
      if (in_ready_4) i++;
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (i != 10) begin
      errors++;
      $display("[TB] FAIL stream_accept: got %0d accepted, want 10", i);
    end
    error_in = 1'b0;
    drain();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; float_in_1 = TA[i]; float_in_2 = TB[i]; side_in = 32'(200 + i);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    rstn  = 1'b0;
    #1;
    checks++;
    if ({ready_4, ready_1, float_out_4, side_out_4, error_out_4, ovf_4, unf_4} !== 69'd0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: got ready=%b%b f4=%h s4=%h, want zeros",
               ready_4, ready_1, float_out_4, side_out_4);
    end
    q4.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    valid = 1'b1; float_in_1 = TA[0]; float_in_2 = TB[0]; side_in = 32'hABCD;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ready_4 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_early k=%0d: got ready_4=%b side=%h, want 0", k, ready_4, side_out_4);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (ready_4 !== 1'b1 || float_out_4 !== 32'h40C00000 || side_out_4 !== 32'hABCD) begin
      errors++;
      $display("[TB] FAIL midreset_lat: got ready=%b f=%h side=%h, want 1 40c00000 0000abcd",
               ready_4, float_out_4, side_out_4);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
